pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and pipeline-control unit for the pipelined ARM core, and the successor to the fixed E/M/W hazard logic. It tracks in-flight register writes in an internal scoreboard shift register covering NSTG post-decode stages. From that scoreboard it generates:
- per-operand forwarding selects for NSRC source operands;
- load-use stalls for a configurable load latency;
- PC-write and taken-branch stalls and flushes;
- a global hold.

It sits beside the datapath, consuming decode-stage fields and driving the stall/flush enables of the pipeline registers.

## Interface
- REGW, 4, register address width
- NSRC, 2, source operands per instruction
- NSTG, 3, tracked stages after decode (0=E, 1=M, …, NSTG-1=W); NSTG ≥ 2
- LDSTG, 2, first stage index at which load data is forwardable; 1 ≤ LDSTG ≤ NSTG-1
- PCREG, 15, register index that aliases the PC
- CNTW, 16, performance counter width
- SELW = $clog2(NSTG), derived, forwarding-select width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- hold  in  1  global freeze (memory wait)
- dec_valid  in  1  decode register holds a real instruction
- dec_src  in  NSRC*REGW  decode source registers, operand i at [i*REGW +: REGW]
- dec_src_used  in  NSRC  operand i actually reads a register
- dec_dst  in  REGW  decode destination register
- dec_regwrite  in  1  instruction writes dec_dst
- dec_load  in  1  instruction is a load
- dec_pcwrite  in  1  instruction writes the PC (pcSrc)
- br_taken_e  in  1  branch in E resolved taken this cycle
- stall_f  out  1  hold PC register
- stall_d  out  1  hold fetch/decode register
- flush_d  out  1  clear fetch/decode register
- flush_e  out  1  clear decode/execute register
- fwd_sel  out  NSRC*SELW  per-operand select for the E-stage operand: 0 = regfile value, k = result of stage k
- ldstall_cnt  out  CNTW  saturating count of load-use stall cycles
- brflush_cnt  out  CNTW  saturating count of taken-branch flush cycles

## Operation
- Each scoreboard entry holds valid, regwrite, dst, load, pcwrite, and for entry 0 also src[NSRC] and src_used[NSRC].
- Advance happens every cycle unless hold=1:
  - entry k+1 ← entry k;
  - entry 0 ← the decode fields when dec_valid & ~stall_d & ~flush_e; otherwise entry 0 becomes a bubble (valid=0).
  - The W entry is discarded on advance. The regfile is write-first, so retired writes need no tracking.
- Availability: entry k's result is forwardable when k ≥ 1 and (~load or k ≥ LDSTG).
- Forwarding, for operand i of entry 0:
  - fwd_sel[i] = the smallest k in 1..NSTG-1 where entry k has valid & regwrite, dst == src[i], and its result is available;
  - fwd_sel[i] = 0 when there is no such k, or when ~src_used[i], or when src[i] == PCREG, or when entry 0 is invalid.
  - Operands are resolved independently of each other.
- Load-use (ldu): dec_valid, and some operand i with dec_src_used[i] and dec_src[i] ≠ PCREG, matches a valid load entry k with dst == dec_src[i] and k+1 < LDSTG.
- pc_pend = (dec_valid & dec_pcwrite) | any valid pcwrite entry in stages 0..NSTG-2.
- pc_w = valid pcwrite entry in stage NSTG-1.
- Output equations, with ldu_eff = ldu & ~br_taken_e:
  - If hold=1: stall_f = stall_d = 1 and flush_d = flush_e = 0.
  - Otherwise:
    - stall_f = ldu_eff | pc_pend
    - stall_d = ldu_eff
    - flush_e = ldu_eff | br_taken_e
    - flush_d = pc_pend | pc_w | br_taken_e
- A taken branch overrides load-use, because the stalled instruction is wrong-path.
- Counters:
  - ldstall_cnt increments on cycles with ldu_eff & ~hold.
  - brflush_cnt increments on cycles with br_taken_e & ~hold.
  - Both saturate at 2^CNTW-1 (no wrap).

## Timing
- All outputs are combinational from scoreboard state and current inputs; there is no added latency.
- The scoreboard updates on the rising edge.
- Reset (reset=0 sampled at an edge):
  - all entries are invalidated and both counters are cleared;
  - while reset=0, all stall/flush outputs are forced to 0 and fwd_sel is forced to 0.
- Reset mid-operation drops all pending loads and PC writes; there is no residual stall after release.
- Under hold: the scoreboard and counters are frozen, and fwd_sel stays stable.
- Load-use stall length is LDSTG-1 cycles for a back-to-back dependency, and 0 once the load is in stage ≥ LDSTG-1.
- A PC-write instruction produces NSTG cycles of stall_f, while it sits in D, E, …, stage NSTG-2. flush_d stays high one further cycle while the instruction is in W.

## Test plan
- ADD r1 followed by SUB using r1 as operand 0 (defaults) -> fwd_sel[0]=1 with SUB in E. With one intervening NOP -> fwd_sel[0]=2. With two NOPs -> fwd_sel[0]=0. fwd_sel[1] stays 0 throughout.
- LDR r2 followed by ADD using r2 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd_sel=2 and ldstall_cnt=1. With LDSTG=3, NSTG=4 -> 2 stall cycles and fwd_sel=3.
- MOV to PCREG (dec_pcwrite=1) entering D -> stall_f=flush_d=1 for 3 cycles, then flush_d=1 with stall_f=0 for 1 cycle, then both 0.
- br_taken_e=1 in the same cycle as a load-use hit -> flush_d=flush_e=1, stall_d=stall_f=0; ldstall_cnt unchanged, brflush_cnt +1.
- hold=1 for 4 cycles with an ALU dependency pending -> stall_f=stall_d=1, flushes 0, fwd_sel constant; after release, forwarding resumes exactly as without hold.
- reset=0 for one cycle with a load in E and a PC write in M -> afterwards all outputs 0 and both counters 0. Separately, with CNTW=2, 5 load-use stalls -> ldstall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bus: decode fields and branch/hold inputs in,
// pipeline stall/flush enables, forwarding selects and counters out.
interface pipe_hazard_ctrl_if #(
    parameter int REGW = 4,
    parameter int NSRC = 2,
    parameter int NSTG = 3,
    parameter int CNTW = 16
);
    localparam int SELW = (NSTG > 1) ? $clog2(NSTG) : 1;

    logic                   hold;
    logic                   dec_valid;
    logic [NSRC*REGW-1:0]   dec_src;
    logic [NSRC-1:0]        dec_src_used;
    logic [REGW-1:0]        dec_dst;
    logic                   dec_regwrite;
    logic                   dec_load;
    logic                   dec_pcwrite;
    logic                   br_taken_e;
    logic                   stall_f;
    logic                   stall_d;
    logic                   flush_d;
    logic                   flush_e;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic [CNTW-1:0]        ldstall_cnt;
    logic [CNTW-1:0]        brflush_cnt;

    modport master (
        output hold, dec_valid, dec_src, dec_src_used, dec_dst,
               dec_regwrite, dec_load, dec_pcwrite, br_taken_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_sel,
               ldstall_cnt, brflush_cnt
    );

    modport slave (
        input  hold, dec_valid, dec_src, dec_src_used, dec_dst,
               dec_regwrite, dec_load, dec_pcwrite, br_taken_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_sel,
               ldstall_cnt, brflush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control unit. A scoreboard shift register
// tracks in-flight writes for NSTG stages after decode (entry 0 = E).
module pipe_hazard_ctrl #(
    parameter int REGW  = 4,
    parameter int NSRC  = 2,
    parameter int NSTG  = 3,
    parameter int LDSTG = 2,
    parameter int PCREG = 15,
    parameter int CNTW  = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int SELW = (NSTG > 1) ? $clog2(NSTG) : 1;
    localparam logic [REGW-1:0] PC_ADDR = REGW'(PCREG);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [NSTG-1:0]      vld_q, vld_d, rw_q, rw_d, ld_q, ld_d, pcw_q, pcw_d;
    logic [REGW-1:0]      dst_q [NSTG];
    logic [REGW-1:0]      dst_d [NSTG];
    logic [NSRC*REGW-1:0] src_q, src_d;
    logic [NSRC-1:0]      used_q, used_d;
    logic [CNTW-1:0]      ldcnt_q, ldcnt_d, brcnt_q, brcnt_d;

    logic                 ldu, ldu_eff, pc_pend, pc_w, issue;
    logic                 stall_f, stall_d, flush_d, flush_e;
    logic [NSRC*SELW-1:0] fwd_sel;

    // Load-use: a decode operand needs a load whose data will not be
    // forwardable when the consumer reaches E next cycle.
    always_comb begin
        ldu = 1'b0;
        for (int k = 0; k < LDSTG - 1; k++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (hz.dec_valid && hz.dec_src_used[i] &&
                    (hz.dec_src[i*REGW +: REGW] != PC_ADDR) &&
                    vld_q[k] && ld_q[k] &&
                    (dst_q[k] == hz.dec_src[i*REGW +: REGW]))
                    ldu = 1'b1;
            end
        end
    end

    assign pc_pend = (hz.dec_valid & hz.dec_pcwrite) |
                     (|(vld_q[NSTG-2:0] & pcw_q[NSTG-2:0]));
    assign pc_w    = vld_q[NSTG-1] & pcw_q[NSTG-1];
    // A taken branch makes the stalled consumer wrong-path, so it wins.
    assign ldu_eff = ldu & ~hz.br_taken_e;

    // Stall/flush enables; reset forces all low, hold freezes front end.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            stall_f = 1'b0;
        end else if (hz.hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else begin
            stall_f = ldu_eff | pc_pend;
            stall_d = ldu_eff;
            flush_e = ldu_eff | hz.br_taken_e;
            flush_d = pc_pend | pc_w | hz.br_taken_e;
        end
    end

    // Forwarding: youngest available producer wins (scan oldest to youngest).
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = NSTG - 1; k >= 1; k--) begin
                if (vld_q[k] && rw_q[k] &&
                    (dst_q[k] == src_q[i*REGW +: REGW]) &&
                    (!ld_q[k] || (k >= LDSTG)))
                    fwd_sel[i*SELW +: SELW] = SELW'(k);
            end
            if (!reset || !vld_q[0] || !used_q[i] ||
                (src_q[i*REGW +: REGW] == PC_ADDR))
                fwd_sel[i*SELW +: SELW] = '0;
        end
    end

    assign issue = hz.dec_valid & ~stall_d & ~flush_e;

    // Scoreboard advance: shift one stage per unheld cycle, bubble on no issue.
    always_comb begin
        vld_d  = vld_q;
        rw_d   = rw_q;
        ld_d   = ld_q;
        pcw_d  = pcw_q;
        dst_d  = dst_q;
        src_d  = src_q;
        used_d = used_q;
        if (!hz.hold) begin
            vld_d    = {vld_q[NSTG-2:0], issue};
            rw_d     = {rw_q[NSTG-2:0],  issue & hz.dec_regwrite};
            ld_d     = {ld_q[NSTG-2:0],  issue & hz.dec_load};
            pcw_d    = {pcw_q[NSTG-2:0], issue & hz.dec_pcwrite};
            dst_d[0] = hz.dec_dst;
            for (int k = 1; k < NSTG; k++) dst_d[k] = dst_q[k-1];
            src_d    = hz.dec_src;
            used_d   = issue ? hz.dec_src_used : '0;
        end
    end

    // Saturating performance counters, frozen under hold.
    always_comb begin
        ldcnt_d = ldcnt_q;
        brcnt_d = brcnt_q;
        if (!hz.hold) begin
            if (ldu_eff && (ldcnt_q != CNT_MAX))       ldcnt_d = ldcnt_q + 1'b1;
            if (hz.br_taken_e && (brcnt_q != CNT_MAX)) brcnt_d = brcnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q   <= '0;
            rw_q    <= '0;
            ld_q    <= '0;
            pcw_q   <= '0;
            for (int k = 0; k < NSTG; k++) dst_q[k] <= '0;
            src_q   <= '0;
            used_q  <= '0;
            ldcnt_q <= '0;
            brcnt_q <= '0;
        end else begin
            vld_q   <= vld_d;
            rw_q    <= rw_d;
            ld_q    <= ld_d;
            pcw_q   <= pcw_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            used_q  <= used_d;
            ldcnt_q <= ldcnt_d;
            brcnt_q <= brcnt_d;
        end
    end

    assign hz.stall_f     = stall_f;
    assign hz.stall_d     = stall_d;
    assign hz.flush_d     = flush_d;
    assign hz.flush_e     = flush_e;
    assign hz.fwd_sel     = fwd_sel;
    assign hz.ldstall_cnt = ldcnt_q;
    assign hz.brflush_cnt = brcnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random-stimulus bench for pipe_hazard_ctrl. Two instances share the same
// decode stream: default geometry, and NSTG=4/LDSTG=3 with 2-bit counters.
// The reference model tracks issued instructions by their issue tick and
// derives each one's stage from its age.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REGW(4), .NSRC(2), .NSTG(3), .CNTW(16)) hz0 ();
    pipe_hazard_ctrl_if #(.REGW(4), .NSRC(2), .NSTG(4), .CNTW(2))  hz1 ();

    pipe_hazard_ctrl dut0 (.clk(clk), .reset(reset), .hz(hz0.slave));
    pipe_hazard_ctrl #(.NSTG(4), .LDSTG(3), .CNTW(2))
        dut1 (.clk(clk), .reset(reset), .hz(hz1.slave));

    typedef struct {
        int cfg;
        int issue;
        int dst;
        int src0;
        int src1;
        bit rw;
        bit ld;
        bit pcw;
        bit used0;
        bit used1;
    } ins_t;

    ins_t q[$];
    int   tick[2];
    int   ldc[2];
    int   brc[2];
    int   n_checks = 0;
    int   n_errors = 0;

    bit hold_s, dv, u0, u1, rw, ld, pcw, br;
    int s0, s1, dst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rand_reg();
        if ($urandom_range(0, 9) == 0) return 15;
        return int'($urandom_range(0, 3));
    endfunction

    // Youngest producer of src at age 1..nstg-1 whose value is available.
    function automatic int best_fwd(input int c, input int nstg, input int ldstg,
                                    input bit used, input int src);
        int best = 0;
        int a;
        if (!used || src == 15) return 0;
        foreach (q[j]) begin
            if (q[j].cfg == c) begin
                a = tick[c] - q[j].issue;
                if (a >= 1 && a <= nstg - 1 && q[j].rw && q[j].dst == src &&
                    (!q[j].ld || a >= ldstg) && (best == 0 || a < best))
                    best = a;
            end
        end
        return best;
    endfunction

    task automatic drive();
        hz0.hold = hold_s;  hz1.hold = hold_s;
        hz0.dec_valid = dv; hz1.dec_valid = dv;
        hz0.dec_src = {4'(s1), 4'(s0)};  hz1.dec_src = {4'(s1), 4'(s0)};
        hz0.dec_src_used = {u1, u0};     hz1.dec_src_used = {u1, u0};
        hz0.dec_dst = 4'(dst);  hz1.dec_dst = 4'(dst);
        hz0.dec_regwrite = rw;  hz1.dec_regwrite = rw;
        hz0.dec_load = ld;      hz1.dec_load = ld;
        hz0.dec_pcwrite = pcw;  hz1.dec_pcwrite = pcw;
        hz0.br_taken_e = br;    hz1.br_taken_e = br;
    endtask

    task automatic model_cfg(input int c, input int nstg, input int ldstg, input int cmax,
                             input logic sf, input logic sd, input logic fd, input logic fe,
                             input logic [31:0] fs, input logic [31:0] ls, input logic [31:0] bs);
        bit ldu = 0, pcp, pc_w = 0, has_e = 0, ldu_eff, issue;
        bit e_sf = 0, e_sd = 0, e_fd = 0, e_fe = 0;
        int f0 = 0, f1 = 0, a;
        ins_t e_ins;
        ins_t n;
        string p;
        p = $sformatf("c%0d", c);
        pcp = dv & pcw;
        foreach (q[j]) begin
            if (q[j].cfg == c) begin
                a = tick[c] - q[j].issue;
                if (a + 1 < ldstg && q[j].ld && dv &&
                    ((u0 && s0 != 15 && q[j].dst == s0) || (u1 && s1 != 15 && q[j].dst == s1)))
                    ldu = 1;
                if (q[j].pcw && a <= nstg - 2) pcp = 1;
                if (q[j].pcw && a == nstg - 1) pc_w = 1;
                if (a == 0) begin has_e = 1; e_ins = q[j]; end
            end
        end
        if (has_e && reset) begin
            f0 = best_fwd(c, nstg, ldstg, e_ins.used0, e_ins.src0);
            f1 = best_fwd(c, nstg, ldstg, e_ins.used1, e_ins.src1);
        end
        ldu_eff = ldu & ~br;
        if (!reset) begin
            e_sf = 0;
        end else if (hold_s) begin
            e_sf = 1; e_sd = 1;
        end else begin
            e_sf = ldu_eff | pcp;
            e_sd = ldu_eff;
            e_fe = ldu_eff | br;
            e_fd = pcp | pc_w | br;
        end
        chk({p, " stall_f"}, 32'(sf), 32'(e_sf));
        chk({p, " stall_d"}, 32'(sd), 32'(e_sd));
        chk({p, " flush_d"}, 32'(fd), 32'(e_fd));
        chk({p, " flush_e"}, 32'(fe), 32'(e_fe));
        chk({p, " fwd_sel"}, fs, 32'(f0 + f1 * 4));
        chk({p, " ldstall_cnt"}, ls, 32'(ldc[c]));
        chk({p, " brflush_cnt"}, bs, 32'(brc[c]));

        if (!reset) begin
            for (int j = q.size() - 1; j >= 0; j--) if (q[j].cfg == c) q.delete(j);
            tick[c] = 0; ldc[c] = 0; brc[c] = 0;
        end else if (!hold_s) begin
            if (ldu_eff && ldc[c] < cmax) ldc[c]++;
            if (br && brc[c] < cmax) brc[c]++;
            issue = dv && !e_sd && !e_fe;
            tick[c]++;
            for (int j = q.size() - 1; j >= 0; j--)
                if (q[j].cfg == c && tick[c] - q[j].issue > nstg - 1) q.delete(j);
            if (issue) begin
                n.cfg = c; n.issue = tick[c]; n.dst = dst; n.src0 = s0; n.src1 = s1;
                n.rw = rw; n.ld = ld; n.pcw = pcw; n.used0 = u0; n.used1 = u1;
                q.push_back(n);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        hold_s = 0; dv = 0; u0 = 0; u1 = 0; rw = 0; ld = 0; pcw = 0; br = 0;
        s0 = 0; s1 = 0; dst = 0;
        drive();
        for (int c = 0; c < 2; c++) begin tick[c] = 0; ldc[c] = 0; brc[c] = 0; end
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            reset  = (cyc < 2 || $urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            hold_s = ($urandom_range(0, 9) == 0);
            br     = ($urandom_range(0, 11) == 0);
            dv     = ($urandom_range(0, 9) < 8);
            s0     = rand_reg();
            s1     = rand_reg();
            u0     = ($urandom_range(0, 3) != 0);
            u1     = ($urandom_range(0, 1) != 0);
            pcw    = ($urandom_range(0, 24) == 0);
            ld     = !pcw && ($urandom_range(0, 2) == 0);
            rw     = pcw || ld || ($urandom_range(0, 4) != 0);
            dst    = pcw ? 15 : rand_reg();
            drive();
            #1;
            model_cfg(0, 3, 2, 65535, hz0.stall_f, hz0.stall_d, hz0.flush_d, hz0.flush_e,
                      32'(hz0.fwd_sel), 32'(hz0.ldstall_cnt), 32'(hz0.brflush_cnt));
            model_cfg(1, 4, 3, 3, hz1.stall_f, hz1.stall_d, hz1.flush_d, hz1.flush_e,
                      32'(hz1.fwd_sel), 32'(hz1.ldstall_cnt), 32'(hz1.brflush_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
